// File: rtl/cnt24_hour_pkg.sv
// Shared constants and load validation for the hour stage of the digital clock chain.
// Hours are held as two BCD digits, 00..23.
package cnt24_hour_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] HOUR_MAX_H = 4'd2;
    localparam logic [BCD_W-1:0] HOUR_MAX_L = 4'd3;
    localparam logic [BCD_W-1:0] BCD_NINE   = 4'd9;
    localparam logic [4:0]       HOUR_NOON  = 5'd12;

    // A load is accepted only for proper BCD digits forming an hour in 00..23.
    function automatic logic hour_load_ok(input logic [BCD_W-1:0] h,
                                          input logic [BCD_W-1:0] l);
        return (h <= HOUR_MAX_H) && (l <= BCD_NINE) &&
               ((h < HOUR_MAX_H) || (l <= HOUR_MAX_L));
    endfunction

endpackage

// File: rtl/cnt24_hour_to12.sv
// Combinational 24h -> display conversion: passes the count through in 24h mode,
// maps to 12..11 with a PM flag in 12h mode. pm reflects hour >= 12 in both modes.
module bcd_hour_to_12
    import cnt24_hour_pkg::*;
(
    input  logic             mode12,
    input  logic [BCD_W-1:0] cnt_H,
    input  logic [BCD_W-1:0] cnt_L,
    output logic [BCD_W-1:0] disp_H,
    output logic [BCD_W-1:0] disp_L,
    output logic             pm
);

    logic [4:0] hour;
    logic [4:0] h12;

    always_comb begin
        hour   = {1'b0, cnt_H} * 5'd10 + {1'b0, cnt_L};
        pm     = (hour >= HOUR_NOON);
        h12    = hour;
        disp_H = cnt_H;
        disp_L = cnt_L;
        if (mode12) begin
            // Midnight shows as 12; afternoon hours fold down by twelve.
            if (hour == 5'd0) begin
                h12 = HOUR_NOON;
            end else if (hour > HOUR_NOON) begin
                h12 = hour - HOUR_NOON;
            end
            if (h12 >= 5'd10) begin
                disp_H = 4'd1;
                disp_L = h12[3:0] - 4'd10;
            end else begin
                disp_H = 4'd0;
                disp_L = h12[3:0];
            end
        end
    end

endmodule

// File: rtl/cnt24_hour.sv
// Hour stage: BCD 00..23 counter driven by the minute carry, with time-set
// (manual increment, direct load) and a registered 12h/24h display path.
module cnt24_hour
    import cnt24_hour_pkg::*;
#(
    parameter int RESET_H    = 0,
    parameter int RESET_L    = 0,
    parameter int CARRY_EDGE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             carry_in,
    input  logic             set_mode,
    input  logic             adj_inc,
    input  logic             load,
    input  logic [BCD_W-1:0] load_H,
    input  logic [BCD_W-1:0] load_L,
    input  logic             mode12,
    output logic [BCD_W-1:0] cnt_H,
    output logic [BCD_W-1:0] cnt_L,
    output logic             day_carry,
    output logic             load_err,
    output logic [BCD_W-1:0] disp_H,
    output logic [BCD_W-1:0] disp_L,
    output logic             pm
);

    localparam logic [BCD_W-1:0] RST_H     = BCD_W'(RESET_H);
    localparam logic [BCD_W-1:0] RST_L     = BCD_W'(RESET_L);
    localparam logic             EDGE_MODE = (CARRY_EDGE != 0);

    logic             carry_q;
    logic             adj_q;
    logic             carry_evt;
    logic             adj_evt;
    logic             wrap;
    logic [BCD_W-1:0] inc_H;
    logic [BCD_W-1:0] inc_L;
    logic [BCD_W-1:0] nxt_H;
    logic [BCD_W-1:0] nxt_L;
    logic             nxt_day_carry;
    logic             nxt_load_err;
    logic [BCD_W-1:0] conv_H;
    logic [BCD_W-1:0] conv_L;
    logic             conv_pm;

    // Carry counting is frozen in set mode; manual increments only count there.
    assign carry_evt = (EDGE_MODE ? (carry_in & ~carry_q) : carry_in) & ~set_mode;
    assign adj_evt   = adj_inc & ~adj_q & set_mode;
    assign wrap      = (cnt_H == HOUR_MAX_H) && (cnt_L == HOUR_MAX_L);

    always_comb begin
        inc_H = cnt_H;
        inc_L = cnt_L + 4'd1;
        if (cnt_L == BCD_NINE) begin
            inc_H = cnt_H + 4'd1;
            inc_L = 4'd0;
        end else if (wrap) begin
            inc_H = 4'd0;
            inc_L = 4'd0;
        end
    end

    // Priority: load, then manual increment, then minute carry.
    always_comb begin
        nxt_H         = cnt_H;
        nxt_L         = cnt_L;
        nxt_day_carry = 1'b0;
        nxt_load_err  = 1'b0;
        if (load) begin
            if (hour_load_ok(load_H, load_L)) begin
                nxt_H = load_H;
                nxt_L = load_L;
            end else begin
                nxt_load_err = 1'b1;
            end
        end else if (adj_evt) begin
            nxt_H = inc_H;
            nxt_L = inc_L;
        end else if (carry_evt) begin
            nxt_H         = inc_H;
            nxt_L         = inc_L;
            nxt_day_carry = wrap;
        end
    end

    bcd_hour_to_12 u_to12 (
        .mode12 (mode12),
        .cnt_H  (cnt_H),
        .cnt_L  (cnt_L),
        .disp_H (conv_H),
        .disp_L (conv_L),
        .pm     (conv_pm)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            carry_q   <= 1'b0;
            adj_q     <= 1'b0;
            cnt_H     <= RST_H;
            cnt_L     <= RST_L;
            day_carry <= 1'b0;
            load_err  <= 1'b0;
            disp_H    <= 4'd0;
            disp_L    <= 4'd0;
            pm        <= 1'b0;
        end else begin
            carry_q   <= carry_in;
            adj_q     <= adj_inc;
            cnt_H     <= nxt_H;
            cnt_L     <= nxt_L;
            day_carry <= nxt_day_carry;
            load_err  <= nxt_load_err;
            disp_H    <= conv_H;
            disp_L    <= conv_L;
            pm        <= conv_pm;
        end
    end

endmodule

// File: tb/tb_cnt24_hour.sv
// Directed bench for cnt24_hour: driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the registered outputs.
module tb_cnt24_hour;

    logic       clk = 1'b0;
    logic       clr;
    logic       carry_in;
    logic       set_mode;
    logic       adj_inc;
    logic       load;
    logic [3:0] load_H;
    logic [3:0] load_L;
    logic       mode12;
    logic [3:0] cnt_H;
    logic [3:0] cnt_L;
    logic       day_carry;
    logic       load_err;
    logic [3:0] disp_H;
    logic [3:0] disp_L;
    logic       pm;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] l;
        logic       dc;
        logic       le;
        logic       chk_disp;
        logic [3:0] dh;
        logic [3:0] dl;
        logic       pm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   hr;

    cnt24_hour #(.RESET_H(0), .RESET_L(0), .CARRY_EDGE(1)) dut (
        .clk       (clk),
        .clr       (clr),
        .carry_in  (carry_in),
        .set_mode  (set_mode),
        .adj_inc   (adj_inc),
        .load      (load),
        .load_H    (load_H),
        .load_L    (load_L),
        .mode12    (mode12),
        .cnt_H     (cnt_H),
        .cnt_L     (cnt_L),
        .day_carry (day_carry),
        .load_err  (load_err),
        .disp_H    (disp_H),
        .disp_L    (disp_L),
        .pm        (pm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are already set; one clock edge, then the expected outputs are queued.
    task automatic tick(input logic [3:0] h, input logic [3:0] l, input logic dc, input logic le);
        exp_t e;
        e = '0;
        e.h = h; e.l = l; e.dc = dc; e.le = le;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick_d(input logic [3:0] h, input logic [3:0] l, input logic dc, input logic le,
                          input logic [3:0] dh, input logic [3:0] dl, input logic epm);
        exp_t e;
        e.h = h; e.l = l; e.dc = dc; e.le = le;
        e.chk_disp = 1'b1; e.dh = dh; e.dl = dl; e.pm = epm;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cnt", {cnt_H, cnt_L}, {mon_e.h, mon_e.l});
            check("day_carry", {7'd0, day_carry}, {7'd0, mon_e.dc});
            check("load_err", {7'd0, load_err}, {7'd0, mon_e.le});
            if (mon_e.chk_disp) begin
                check("disp", {disp_H, disp_L}, {mon_e.dh, mon_e.dl});
                check("pm", {7'd0, pm}, {7'd0, mon_e.pm});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; carry_in = 1'b0; set_mode = 1'b0; adj_inc = 1'b0;
        load = 1'b0; load_H = 4'd0; load_L = 4'd0; mode12 = 1'b0;
        @(negedge clk);
        tick_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        clr = 1'b0;

        // 24 carry rises: 01..23 then 00 with day_carry on the wrap only.
        for (int i = 1; i <= 24; i++) begin
            hr = i % 24;
            carry_in = 1'b1;
            tick(4'(hr / 10), 4'(hr % 10), (i == 24), 1'b0);
            carry_in = 1'b0;
            tick_d(4'(hr / 10), 4'(hr % 10), 1'b0, 1'b0, 4'(hr / 10), 4'(hr % 10), (hr >= 12));
        end

        // Manual wrap 23 -> 00 in set mode gives no day carry.
        load = 1'b1; load_H = 4'd2; load_L = 4'd3;
        tick(4'd2, 4'd3, 1'b0, 1'b0);
        load = 1'b0; set_mode = 1'b1; adj_inc = 1'b1;
        tick(4'd0, 4'd0, 1'b0, 1'b0);
        adj_inc = 1'b0;
        tick(4'd0, 4'd0, 1'b0, 1'b0);

        // Carry toggling in set mode is dropped; leaving set mode with carry held high too.
        repeat (5) begin
            carry_in = 1'b1; tick(4'd0, 4'd0, 1'b0, 1'b0);
            carry_in = 1'b0; tick(4'd0, 4'd0, 1'b0, 1'b0);
        end
        carry_in = 1'b1; tick(4'd0, 4'd0, 1'b0, 1'b0);
        set_mode = 1'b0; tick(4'd0, 4'd0, 1'b0, 1'b0);
        carry_in = 1'b0; tick(4'd0, 4'd0, 1'b0, 1'b0);

        // adj_inc outside set mode is ignored.
        adj_inc = 1'b1; tick(4'd0, 4'd0, 1'b0, 1'b0);
        adj_inc = 1'b0; tick(4'd0, 4'd0, 1'b0, 1'b0);

        // Loads: valid, out of range, bad BCD, then 19 + carry -> 20.
        load = 1'b1; load_H = 4'd1; load_L = 4'd7; tick(4'd1, 4'd7, 1'b0, 1'b0);
        load_H = 4'd2; load_L = 4'd4; tick(4'd1, 4'd7, 1'b0, 1'b1);
        load_H = 4'd0; load_L = 4'hA; tick(4'd1, 4'd7, 1'b0, 1'b1);
        load_H = 4'd3; load_L = 4'd0; tick(4'd1, 4'd7, 1'b0, 1'b1);
        load_H = 4'd1; load_L = 4'd9; tick(4'd1, 4'd9, 1'b0, 1'b0);
        load = 1'b0; tick(4'd1, 4'd9, 1'b0, 1'b0);
        carry_in = 1'b1; tick(4'd2, 4'd0, 1'b0, 1'b0);
        carry_in = 1'b0; tick(4'd2, 4'd0, 1'b0, 1'b0);

        // Carry and load in the same clock at 23: load wins, no day carry.
        load = 1'b1; load_H = 4'd2; load_L = 4'd3; tick(4'd2, 4'd3, 1'b0, 1'b0);
        load = 1'b0; tick(4'd2, 4'd3, 1'b0, 1'b0);
        carry_in = 1'b1; load = 1'b1; load_H = 4'd0; load_L = 4'd5;
        tick(4'd0, 4'd5, 1'b0, 1'b0);
        carry_in = 1'b0; load = 1'b0; tick(4'd0, 4'd5, 1'b0, 1'b0);

        // 12h display, one clock behind the count.
        mode12 = 1'b1;
        load = 1'b1; load_H = 4'd0; load_L = 4'd0; tick(4'd0, 4'd0, 1'b0, 1'b0);
        load = 1'b0; tick_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
        load = 1'b1; load_H = 4'd1; load_L = 4'd2;
        tick_d(4'd1, 4'd2, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
        load = 1'b0; tick_d(4'd1, 4'd2, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1);
        load = 1'b1; load_H = 4'd1; load_L = 4'd3; tick(4'd1, 4'd3, 1'b0, 1'b0);
        load = 1'b0; tick_d(4'd1, 4'd3, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1);
        load = 1'b1; load_H = 4'd1; load_L = 4'd1; tick(4'd1, 4'd1, 1'b0, 1'b0);
        load = 1'b0; tick_d(4'd1, 4'd1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0);
        load = 1'b1; load_H = 4'd2; load_L = 4'd3; tick(4'd2, 4'd3, 1'b0, 1'b0);
        load = 1'b0; tick_d(4'd2, 4'd3, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1);
        mode12 = 1'b0; tick_d(4'd2, 4'd3, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1);

        // Asynchronous clear between edges at 09.
        load = 1'b1; load_H = 4'd0; load_L = 4'd9; tick(4'd0, 4'd9, 1'b0, 1'b0);
        load = 1'b0; tick_d(4'd0, 4'd9, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
        #2 clr = 1'b1;
        #1;
        check("async_clr_cnt", {cnt_H, cnt_L}, 8'h00);
        check("async_clr_disp", {disp_H, disp_L}, 8'h00);
        check("async_clr_flags", {5'd0, day_carry, load_err, pm}, 8'h00);
        tick_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        clr = 1'b0;
        carry_in = 1'b1; tick(4'd0, 4'd1, 1'b0, 1'b0);
        carry_in = 1'b0; tick(4'd0, 4'd1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
